input_seq_ctrl: RTL and testbench

Sequencer that streams LSTM input vectors out of the input-vector ROM (`mem_input_x`) into the LSTM forward datapath. On `start` it walks one selected sequence: NUM_ITERATIONS time steps of NUM words each, at one word per cycle under a valid/ready handshake. After each time step it waits for the datapath's `step_ack` before starting the next step. It sits between the ROM's combinational `addr`/`data` port and the LSTM top level.

---
 rtl/lstm_pkg.sv | 26 ++
 rtl/seq_idx_counter.sv | 56 +++++
 rtl/input_seq_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_input_seq_ctrl.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_pkg.sv
// Shared types, default dimensions and the input-ROM address helper
// for the LSTM sequencers.
package lstm_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE     = 2'd0,
    SEQ_STREAM   = 2'd1,
    SEQ_WAIT_ACK = 2'd2
  } seq_state_t;

  localparam int LSTM_NUM            = 45;
  localparam int LSTM_NUM_ITERATIONS = 8;
  localparam int LSTM_NUM_SEQ        = 2;

  // Flat ROM layout: sequences of time steps of NUM words each.
  function automatic logic [31:0] input_addr(
    input logic [31:0] seq,
    input logic [31:0] step,
    input logic [31:0] feat,
    input logic [31:0] num      = 32'(LSTM_NUM),
    input logic [31:0] num_iter = 32'(LSTM_NUM_ITERATIONS)
  );
    return (seq * num_iter + step) * num + feat;
  endfunction

endpackage

// File: rtl/seq_idx_counter.sv
// Nested feature/step index counter: feat wraps into step, step wraps to 0.
// Shared by the input and weight sequencers.
module seq_idx_counter #(
  parameter int FEAT_N = 45,
  parameter int STEP_N = 8,
  parameter int FEAT_W = (FEAT_N > 1) ? $clog2(FEAT_N) : 1,
  parameter int STEP_W = (STEP_N > 1) ? $clog2(STEP_N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              feat_inc,
  input  logic              step_inc,
  output logic [FEAT_W-1:0] feat,
  output logic [STEP_W-1:0] step,
  output logic              feat_last,
  output logic              step_last
);

  logic [FEAT_W-1:0] feat_q, feat_d;
  logic [STEP_W-1:0] step_q, step_d;

  assign feat      = feat_q;
  assign step      = step_q;
  assign feat_last = (feat_q == FEAT_W'(FEAT_N - 1));
  assign step_last = (step_q == STEP_W'(STEP_N - 1));

  // Next-index logic; clear beats step_inc beats feat_inc.
  always_comb begin
    feat_d = feat_q;
    step_d = step_q;
    if (clr) begin
      feat_d = '0;
      step_d = '0;
    end else if (step_inc || (feat_inc && feat_last)) begin
      feat_d = '0;
      step_d = step_last ? '0 : step_q + STEP_W'(1);
    end else if (feat_inc) begin
      feat_d = feat_q + FEAT_W'(1);
    end else begin
      feat_d = feat_q;
    end
  end

  // Index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_q <= '0;
      step_q <= '0;
    end else begin
      feat_q <= feat_d;
      step_q <= step_d;
    end
  end

endmodule

// File: rtl/input_seq_ctrl.sv
// Streams one LSTM input sequence from the input-vector ROM into the forward
// datapath, one word per cycle, pausing for step_ack after every time step.
module input_seq_ctrl
  import lstm_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int NUM            = LSTM_NUM,
  parameter int NUM_ITERATIONS = LSTM_NUM_ITERATIONS,
  parameter int NUM_SEQ        = LSTM_NUM_SEQ,
  localparam int SEQ_W  = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1,
  localparam int STEP_W = (NUM_ITERATIONS > 1) ? $clog2(NUM_ITERATIONS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [SEQ_W-1:0]        seq_sel,
  input  logic                    abort,
  output logic [WIDTH-1:0]        mem_addr,
  input  logic signed [WIDTH-1:0] mem_data,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_first,
  output logic                    out_last,
  output logic [STEP_W-1:0]       step_idx,
  input  logic                    step_ack,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int FEAT_W = (NUM > 1) ? $clog2(NUM) : 1;

  seq_state_t state_q, state_d;
  logic [SEQ_W-1:0]        seq_q, seq_d;
  logic signed [WIDTH-1:0] out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_first_q, out_first_d;
  logic                    out_last_q, out_last_d;
  logic [STEP_W-1:0]       step_idx_q, step_idx_d;
  logic                    fetch_done_q, fetch_done_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic              cnt_clr, feat_inc, step_inc;
  logic [FEAT_W-1:0] feat;
  logic [STEP_W-1:0] step;
  logic              feat_last, step_last;
  logic              load_ok, accept;

  seq_idx_counter #(
    .FEAT_N (NUM),
    .STEP_N (NUM_ITERATIONS),
    .FEAT_W (FEAT_W),
    .STEP_W (STEP_W)
  ) u_idx (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .feat_inc  (feat_inc),
    .step_inc  (step_inc),
    .feat      (feat),
    .step      (step),
    .feat_last (feat_last),
    .step_last (step_last)
  );

  // Address follows the counters, so out_ready may reach mem_addr but never out_data.
  assign mem_addr = WIDTH'(input_addr(32'(seq_q), 32'(step), 32'(feat),
                                      32'(NUM), 32'(NUM_ITERATIONS)));
  assign load_ok  = !out_valid_q || out_ready;
  assign accept   = out_valid_q && out_ready;

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign step_idx  = step_idx_q;
  assign busy      = (state_q != SEQ_IDLE);
  assign done      = done_q;
  assign err       = err_q;

  // Next-state and output-register logic.
  always_comb begin
    state_d      = state_q;
    seq_d        = seq_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_first_d  = out_first_q;
    out_last_d   = out_last_q;
    step_idx_d   = step_idx_q;
    fetch_done_d = fetch_done_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    cnt_clr      = 1'b0;
    feat_inc     = 1'b0;
    step_inc     = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          if (32'(seq_sel) < 32'(NUM_SEQ)) begin
            seq_d        = seq_sel;
            cnt_clr      = 1'b1;
            fetch_done_d = 1'b0;
            state_d      = SEQ_STREAM;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = SEQ_IDLE;
        end
      end
      SEQ_STREAM: begin
        if (!fetch_done_q) begin
          if (load_ok) begin
            out_data_d  = mem_data;
            out_valid_d = 1'b1;
            out_first_d = (feat == '0);
            out_last_d  = feat_last;
            step_idx_d  = step;
            if (feat_last) begin
              fetch_done_d = 1'b1;
            end else begin
              feat_inc = 1'b1;
            end
          end else begin
            out_valid_d = out_valid_q;
          end
        end else if (accept) begin
          // Last word of the step has left; the datapath now runs the cell.
          out_valid_d = 1'b0;
          state_d     = SEQ_WAIT_ACK;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      SEQ_WAIT_ACK: begin
        if (step_ack) begin
          if (!step_last) begin
            step_inc     = 1'b1;
            fetch_done_d = 1'b0;
            state_d      = SEQ_STREAM;
          end else begin
            done_d  = 1'b1;
            state_d = SEQ_IDLE;
          end
        end else begin
          state_d = SEQ_WAIT_ACK;
        end
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase

    if (abort) begin
      state_d      = SEQ_IDLE;
      out_valid_d  = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      cnt_clr      = 1'b1;
      feat_inc     = 1'b0;
      step_inc     = 1'b0;
      fetch_done_d = 1'b0;
    end else begin
      cnt_clr = cnt_clr;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SEQ_IDLE;
      seq_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
      step_idx_q   <= '0;
      fetch_done_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      seq_q        <= seq_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_first_q  <= out_first_d;
      out_last_q   <= out_last_d;
      step_idx_q   <= step_idx_d;
      fetch_done_q <= fetch_done_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_input_seq_ctrl.sv
// Randomized self-checking bench for input_seq_ctrl against a flat-list model
// of the ROM walk (sequence -> steps -> features).
module tb_input_seq_ctrl;

  localparam int N  = 45;
  localparam int IT = 8;

  typedef struct packed {
    logic [31:0] data;
    logic        first;
    logic        last;
    logic [2:0]  step;
    logic [31:0] cyc;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, out_ready = 1'b0, step_ack = 1'b0;
  logic [0:0] seq_sel = 1'b0;
  logic [31:0] mem_addr;
  logic signed [31:0] mem_data, out_data;
  logic out_valid, out_first, out_last, busy, done, err;
  logic [2:0] step_idx;

  // Small second instance with three sequences so an out-of-range select is encodable.
  logic e_start = 1'b0, e_abort = 1'b0, e_out_ready = 1'b0, e_step_ack = 1'b0;
  logic [1:0] e_seq_sel = 2'd0;
  logic [31:0] e_mem_addr;
  logic signed [31:0] e_mem_data, e_out_data;
  logic e_out_valid, e_out_first, e_out_last, e_busy, e_done, e_err;
  logic [0:0] e_step_idx;

  int checks = 0;
  int failures = 0;

  word_t got_q[$];
  word_t exp_q[$];
  int hold_viol, done_cnt, first_valid_cyc, turn_min, turn_max, done_lat;
  logic [31:0] max_addr;
  logic timed_out, busy_after_start, busy_at_done;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0001_2345;
  endfunction

  assign mem_data   = rom_word(mem_addr);
  assign e_mem_data = rom_word(e_mem_addr);

  input_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seq_sel(seq_sel), .abort(abort),
    .mem_addr(mem_addr), .mem_data(mem_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_first(out_first),
    .out_last(out_last), .step_idx(step_idx), .step_ack(step_ack),
    .busy(busy), .done(done), .err(err)
  );

  input_seq_ctrl #(.WIDTH(32), .NUM(4), .NUM_ITERATIONS(2), .NUM_SEQ(3)) dut_e (
    .clk(clk), .rst_n(rst_n), .start(e_start), .seq_sel(e_seq_sel), .abort(e_abort),
    .mem_addr(e_mem_addr), .mem_data(e_mem_data), .out_data(e_out_data),
    .out_valid(e_out_valid), .out_ready(e_out_ready), .out_first(e_out_first),
    .out_last(e_out_last), .step_idx(e_step_idx), .step_ack(e_step_ack),
    .busy(e_busy), .done(e_done), .err(e_err)
  );

  // Reference: every word of the sequence in ROM order with its step/feature flags.
  task automatic build_exp(input int seq);
    word_t w;
    exp_q.delete();
    for (int t = 0; t < IT; t++) begin
      for (int f = 0; f < N; f++) begin
        w.data  = rom_word(32'((seq * IT + t) * N + f));
        w.first = (f == 0);
        w.last  = (f == N - 1);
        w.step  = 3'(t);
        w.cyc   = 32'd0;
        exp_q.push_back(w);
      end
    end
  endtask

  // Drives one whole sequence and records what the DUT handed over.
  task automatic run_seq(input int seq, input int ready_pct, input int ack_delay, input bit noise);
    int cyc, ack_cnt, ack_cyc;
    logic hold_pending;
    word_t h, w;
    got_q.delete();
    hold_viol = 0; done_cnt = 0; max_addr = 32'd0; timed_out = 1'b0;
    first_valid_cyc = -1; turn_min = 1000; turn_max = 0; done_lat = -1; busy_at_done = 1'b1;
    ack_cnt = -1; ack_cyc = -1; hold_pending = 1'b0; cyc = 0; h = '0;
    seq_sel = 1'(seq); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_after_start = busy;
    while (done_cnt == 0) begin
      if (hold_pending && (!out_valid || out_data !== h.data || out_first !== h.first ||
                           out_last !== h.last || step_idx !== h.step)) hold_viol++;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (ack_cyc >= 0 && out_valid && out_first) begin
        if (cyc - ack_cyc < turn_min) turn_min = cyc - ack_cyc;
        if (cyc - ack_cyc > turn_max) turn_max = cyc - ack_cyc;
        ack_cyc = -1;
      end
      if (mem_addr > max_addr) max_addr = mem_addr;
      if (done) begin
        done_cnt++;
        done_lat = cyc - ack_cyc;
        busy_at_done = busy;
        break;
      end
      out_ready = ($urandom_range(99) < ready_pct);
      step_ack = 1'b0;
      start = 1'b0;
      if (ack_cnt == 0) begin
        step_ack = 1'b1; ack_cyc = cyc; ack_cnt = -1;
      end else if (ack_cnt > 0) begin
        ack_cnt--;
      end else if (noise && out_valid && !out_last && $urandom_range(9) == 0) begin
        step_ack = 1'b1;
      end
      if (noise && $urandom_range(19) == 0) begin
        start = 1'b1; seq_sel = ~seq_sel;
      end
      if (out_valid && out_ready) begin
        w.data = out_data; w.first = out_first; w.last = out_last;
        w.step = step_idx; w.cyc = 32'(cyc);
        got_q.push_back(w);
        if (out_last) ack_cnt = ack_delay;
        hold_pending = 1'b0;
      end else begin
        hold_pending = out_valid;
        h.data = out_data; h.first = out_first; h.last = out_last; h.step = step_idx;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc > 20000) begin
        timed_out = 1'b1;
        break;
      end
    end
    out_ready = 1'b0; step_ack = 1'b0; start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    checks++;
    if ({out_valid, out_first, out_last, busy, done, err} !== 6'b0 ||
        out_data !== 32'sd0 || step_idx !== 3'd0 || mem_addr !== 32'd0) begin
      failures++;
      $display("FAIL reset_in got valid=%0b busy=%0b data=%h addr=%0d step=%0d want all 0",
               out_valid, busy, out_data, mem_addr, step_idx);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, busy, done, err} !== 4'b0 || mem_addr !== 32'd0 || out_data !== 32'sd0) begin
      failures++;
      $display("FAIL reset_idle got valid=%0b busy=%0b done=%0b err=%0b addr=%0d want 0",
               out_valid, busy, done, err, mem_addr);
    end
  endtask

  task automatic test_full_stream;
    run_seq(0, 100, 3, 1'b0);
    build_exp(0);
    checks++;
    if (timed_out !== 1'b0 || got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL full_count got=%0d timeout=%0b want=%0d", got_q.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if ({got_q[i].data, got_q[i].first, got_q[i].last, got_q[i].step} !==
          {exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].step}) begin
        failures++;
        $display("FAIL full_word[%0d] got=%h f%0b l%0b s%0d want=%h f%0b l%0b s%0d", i,
                 got_q[i].data, got_q[i].first, got_q[i].last, got_q[i].step,
                 exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].step);
      end
      if (!exp_q[i].first) begin
        checks++;
        if (got_q[i].cyc !== got_q[i-1].cyc + 32'd1) begin
          failures++;
          $display("FAIL full_throughput[%0d] got cycle=%0d want=%0d", i, got_q[i].cyc, got_q[i-1].cyc + 1);
        end
      end
    end
    checks++;
    if (done_cnt != 1 || done_lat != 1 || busy_at_done !== 1'b0) begin
      failures++;
      $display("FAIL full_done got cnt=%0d lat=%0d busy=%0b want 1 1 0", done_cnt, done_lat, busy_at_done);
    end
    checks++;
    if (first_valid_cyc != 1 || busy_after_start !== 1'b1) begin
      failures++;
      $display("FAIL full_latency got first_valid=%0d busy=%0b want 1 1", first_valid_cyc, busy_after_start);
    end
    checks++;
    if (turn_min != 2 || turn_max != 2) begin
      failures++;
      $display("FAIL full_turnaround got min=%0d max=%0d want 2 2", turn_min, turn_max);
    end
  endtask

  task automatic test_second_seq;
    run_seq(1, 100, 0, 1'b0);
    build_exp(1);
    checks++;
    if (timed_out !== 1'b0 || got_q.size() != exp_q.size() || done_cnt != 1) begin
      failures++;
      $display("FAIL seq1_count got=%0d done=%0d want=%0d done=1", got_q.size(), done_cnt, exp_q.size());
    end
    if (got_q.size() > 0) begin
      checks++;
      if (got_q[0].data !== rom_word(32'd360) || got_q[got_q.size()-1].data !== rom_word(32'd719)) begin
        failures++;
        $display("FAIL seq1_ends got=%h..%h want=%h..%h", got_q[0].data, got_q[got_q.size()-1].data,
                 rom_word(32'd360), rom_word(32'd719));
      end
    end
    checks++;
    if (max_addr > 32'd719) begin
      failures++;
      $display("FAIL seq1_max_addr got=%0d want<=719", max_addr);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if ({got_q[i].data, got_q[i].first, got_q[i].last, got_q[i].step} !==
          {exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].step}) begin
        failures++;
        $display("FAIL seq1_word[%0d] got=%h want=%h", i, got_q[i].data, exp_q[i].data);
      end
    end
  endtask

  task automatic test_backpressure;
    run_seq(0, 30, 2, 1'b0);
    build_exp(0);
    checks++;
    if (timed_out !== 1'b0 || got_q.size() != exp_q.size() || hold_viol != 0) begin
      failures++;
      $display("FAIL bp_stream got words=%0d hold_viol=%0d timeout=%0b want=%0d 0 0",
               got_q.size(), hold_viol, timed_out, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if ({got_q[i].data, got_q[i].first, got_q[i].last, got_q[i].step} !==
          {exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].step}) begin
        failures++;
        $display("FAIL bp_word[%0d] got=%h want=%h", i, got_q[i].data, exp_q[i].data);
      end
    end
  endtask

  task automatic test_early_ack_busy_start;
    run_seq(1, 70, 1, 1'b1);
    build_exp(1);
    checks++;
    if (timed_out !== 1'b0 || got_q.size() != exp_q.size() || done_cnt != 1 || hold_viol != 0) begin
      failures++;
      $display("FAIL noise_stream got words=%0d done=%0d hold_viol=%0d want=%0d 1 0",
               got_q.size(), done_cnt, hold_viol, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if ({got_q[i].data, got_q[i].step} !== {exp_q[i].data, exp_q[i].step}) begin
        failures++;
        $display("FAIL noise_word[%0d] got=%h s%0d want=%h s%0d", i,
                 got_q[i].data, got_q[i].step, exp_q[i].data, exp_q[i].step);
      end
    end
  endtask

  task automatic test_invalid_select;
    e_seq_sel = 2'd3; e_start = 1'b1;
    @(posedge clk); #1;
    e_start = 1'b0;
    checks++;
    if (e_err !== 1'b1 || e_busy !== 1'b0) begin
      failures++;
      $display("FAIL bad_sel_err got err=%0b busy=%0b want 1 0", e_err, e_busy);
    end
    @(posedge clk); #1;
    checks++;
    if (e_err !== 1'b0 || e_busy !== 1'b0) begin
      failures++;
      $display("FAIL bad_sel_after got err=%0b busy=%0b want 0 0", e_err, e_busy);
    end
    e_seq_sel = 2'd2; e_start = 1'b1;
    @(posedge clk); #1;
    e_start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (e_busy !== 1'b1 || e_err !== 1'b0 || e_out_valid !== 1'b1 || e_out_data !== rom_word(32'd16)) begin
      failures++;
      $display("FAIL last_sel_start got busy=%0b valid=%0b data=%h want 1 1 %h",
               e_busy, e_out_valid, e_out_data, rom_word(32'd16));
    end
    e_abort = 1'b1;
    @(posedge clk); #1;
    e_abort = 1'b0;
    checks++;
    if (e_out_valid !== 1'b0 || e_busy !== 1'b0) begin
      failures++;
      $display("FAIL small_abort got valid=%0b busy=%0b want 0 0", e_out_valid, e_busy);
    end
  endtask

  task automatic test_abort;
    int ack_cnt;
    logic found, saw_done;
    seq_sel = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0; ack_cnt = -1;
    for (int c = 0; c < 2000 && !found; c++) begin
      if (out_valid && step_idx == 3'd3 && out_data === rom_word(32'(3 * N + 10))) begin
        found = 1'b1;
      end else begin
        out_ready = 1'b1;
        step_ack = 1'b0;
        if (ack_cnt == 0) begin
          step_ack = 1'b1; ack_cnt = -1;
        end else if (ack_cnt > 0) begin
          ack_cnt--;
        end
        if (out_valid && out_last) ack_cnt = 1;
        @(posedge clk); #1;
      end
    end
    checks++;
    if (found !== 1'b1) begin
      failures++;
      $display("FAIL abort_reach got found=%0b want 1", found);
    end
    abort = 1'b1; step_ack = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; step_ack = 1'b0; start = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_next got valid=%0b busy=%0b done=%0b want 0 0 0", out_valid, busy, done);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_quiet got done_or_busy=%0b want 0", saw_done);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 10 && !out_valid; c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== rom_word(32'd0) || out_first !== 1'b1 || step_idx !== 3'd0) begin
      failures++;
      $display("FAIL abort_restart got valid=%0b data=%h first=%0b step=%0d want 1 %h 1 0",
               out_valid, out_data, out_first, step_idx, rom_word(32'd0));
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic test_reset_midstream;
    seq_sel = 1'b1; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre got valid=%0b busy=%0b want 1 1", out_valid, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_first, out_last, busy, done, err} !== 6'b0 ||
        out_data !== 32'sd0 || step_idx !== 3'd0 || mem_addr !== 32'd0) begin
      failures++;
      $display("FAIL rst_async got valid=%0b busy=%0b data=%h addr=%0d step=%0d want all 0",
               out_valid, busy, out_data, mem_addr, step_idx);
    end
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_release got valid=%0b busy=%0b want 0 0", out_valid, busy);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_full_stream();
    test_second_seq();
    test_backpressure();
    test_early_ack_busy_start();
    test_invalid_select();
    test_abort();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
